// File: rtl/dmem_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dmem_responder: CPU data-port RAM with post-reset clear sweep and status.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          DEPTH     = 1024,
  parameter int          IDX_W     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  input  logic        dmem_r,
  input  logic        dmem_w,
  output logic [31:0] dmem_data,
  output logic        busy,
  output logic        err_range,
  output logic        err_align,
  output logic        err_busy,
  output logic [31:0] err_addr,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [29:0]      DEPTH_WORDS = 30'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             err_range_q, err_range_d;
  logic             err_align_q, err_align_d;
  logic             err_busy_q, err_busy_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [15:0]      rd_count_q, rd_count_d;
  logic [15:0]      wr_count_q, wr_count_d;

  logic [31:0]      mem [DEPTH];

  logic             borrow;
  logic [29:0]      off_word;
  logic             in_range;
  logic             misaligned;
  logic [IDX_W-1:0] idx;
  logic             busy_now;
  logic             access;
  logic             req_ok;
  logic             rd_en;
  logic             wr_en;

  // Word offset (data_addr - BASE_ADDR) >> 2, built from the upper bits plus the low-bit borrow.
  assign borrow     = data_addr[1:0] < BASE_ADDR[1:0];
  assign off_word   = data_addr[31:2] - BASE_ADDR[31:2] - {29'd0, borrow};
  assign in_range   = (data_addr >= BASE_ADDR) && (off_word < DEPTH_WORDS);
  assign misaligned = |data_addr[1:0];
  assign idx        = off_word[IDX_W-1:0];
  assign busy_now   = (state_q == CLEAR);
  assign access     = dmem_r | dmem_w;
  assign req_ok     = in_range && !misaligned && !busy_now;
  assign rd_en      = dmem_r && req_ok;
  assign wr_en      = dmem_w && req_ok;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    err_range_d = err_range_q;
    err_align_d = err_align_q;
    err_busy_d  = err_busy_q;
    err_addr_d  = err_addr_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;

    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_IDX) state_d = READY;
    end

    if (access) begin
      if (!in_range) err_range_d = 1'b1;
      if (misaligned) err_align_d = 1'b1;
      if (busy_now) err_busy_d = 1'b1;
      // Capture only the address of the very first error since reset.
      if (!(err_range_q || err_align_q || err_busy_q) &&
          (!in_range || misaligned || busy_now))
        err_addr_d = data_addr;
    end

    if (rd_en && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
    if (wr_en && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      err_range_q <= 1'b0;
      err_align_q <= 1'b0;
      err_busy_q  <= 1'b0;
      err_addr_q  <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      err_range_q <= err_range_d;
      err_align_q <= err_align_d;
      err_busy_q  <= err_busy_d;
      err_addr_q  <= err_addr_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Storage carries no reset; the sweep owns the write port until READY.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[ptr_q] <= '0;
    else if (wr_en)       mem[idx]   <= w_data;
  end

  assign dmem_data = rd_en ? mem[idx] : 32'h0;
  assign busy      = busy_now;
  assign err_range = err_range_q;
  assign err_align = err_align_q;
  assign err_busy  = err_busy_q;
  assign err_addr  = err_addr_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dmem_responder: directed self-checking bench for dmem_responder.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_addr = '0;
  logic [31:0] w_data = '0;
  logic        dmem_r = 1'b0;
  logic        dmem_w = 1'b0;
  logic [31:0] dmem_data;
  logic        busy, err_range, err_align, err_busy;
  logic [31:0] err_addr;
  logic [15:0] rd_count, wr_count;

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  always #5 clk = ~clk;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .w_data(w_data),
    .dmem_r(dmem_r), .dmem_w(dmem_w), .dmem_data(dmem_data), .busy(busy),
    .err_range(err_range), .err_align(err_align), .err_busy(err_busy),
    .err_addr(err_addr), .rd_count(rd_count), .wr_count(wr_count)
  );

  task automatic idle();
    dmem_r = 1'b0; dmem_w = 1'b0; data_addr = '0; w_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (3) @(negedge clk);
    data_addr = BASE; dmem_r = 1'b1; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if ({err_range, err_align, err_busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {err_range, err_align, err_busy}); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
    checks++; if (rd_count !== 16'h0 || wr_count !== 16'h0) begin errors++; $display("FAIL reset_counts got=%h/%h exp=0/0", rd_count, wr_count); end
    checks++; if (dmem_data !== 32'h0) begin errors++; $display("FAIL reset_dmem_data got=%h exp=0", dmem_data); end
    dmem_r = 1'b0;
  endtask

  task automatic test_sweep();
    int n;
    @(negedge clk); rst = 1'b0; n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL sweep_len got=%0d exp=%0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); data_addr = BASE + 32'(4 * i); dmem_r = 1'b1; #1;
      checks++; if (dmem_data !== 32'h0) begin errors++; $display("FAIL sweep_zero[%0d] got=%h exp=0", i, dmem_data); end
      exp_rd++;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_write_read();
    @(negedge clk); dmem_w = 1'b1; data_addr = BASE + 32'h8; w_data = 32'hDEAD_BEEF; exp_wr++;
    @(negedge clk); dmem_w = 1'b0; dmem_r = 1'b1; #1; exp_rd++;
    checks++; if (dmem_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_data got=%h exp=deadbeef", dmem_data); end
    // Last word of the window.
    @(negedge clk); dmem_r = 1'b0; dmem_w = 1'b1; data_addr = BASE + 32'h3C; w_data = 32'hA5A5_5A5A; exp_wr++;
    @(negedge clk); dmem_w = 1'b0; dmem_r = 1'b1; #1; exp_rd++;
    checks++; if (dmem_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL last_word got=%h exp=a5a55a5a", dmem_data); end
    @(negedge clk); idle(); #1;
    checks++; if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL wr_rd_counts got=%0d/%0d exp=%0d/%0d", wr_count, rd_count, exp_wr, exp_rd); end
  endtask

  task automatic test_simul_rw();
    @(negedge clk); dmem_w = 1'b1; data_addr = BASE + 32'h4; w_data = 32'h1111_1111; exp_wr++;
    @(negedge clk); dmem_r = 1'b1; w_data = 32'h2222_2222; #1; exp_rd++; exp_wr++;
    checks++; if (dmem_data !== 32'h1111_1111) begin errors++; $display("FAIL simul_old got=%h exp=11111111", dmem_data); end
    @(negedge clk); dmem_w = 1'b0; #1; exp_rd++;
    checks++; if (dmem_data !== 32'h2222_2222) begin errors++; $display("FAIL simul_new got=%h exp=22222222", dmem_data); end
    @(negedge clk); idle(); #1;
    checks++; if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL simul_counts got=%0d/%0d exp=%0d/%0d", wr_count, rd_count, exp_wr, exp_rd); end
  endtask

  task automatic test_errors();
    @(negedge clk); dmem_w = 1'b1; data_addr = BASE + 32'h6; w_data = 32'hBAD0_BAD0;
    @(negedge clk); dmem_w = 1'b0; #1;
    checks++; if ({err_range, err_align, err_busy} !== 3'b010) begin errors++; $display("FAIL align_flags got=%b exp=010", {err_range, err_align, err_busy}); end
    dmem_r = 1'b1; data_addr = 32'h0FFF_FFFC; #1;
    checks++; if (dmem_data !== 32'h0) begin errors++; $display("FAIL below_base_data got=%h exp=0", dmem_data); end
    @(negedge clk); data_addr = BASE + 32'h40; #1;
    checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL range_flag got=%b exp=1", err_range); end
    checks++; if (dmem_data !== 32'h0) begin errors++; $display("FAIL above_top_data got=%h exp=0", dmem_data); end
    @(negedge clk); idle(); #1;
    checks++; if (err_addr !== 32'h1001_0006) begin errors++; $display("FAIL first_err_addr got=%h exp=10010006", err_addr); end
    checks++; if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL err_counts got=%0d/%0d exp=%0d/%0d", wr_count, rd_count, exp_wr, exp_rd); end
    dmem_r = 1'b1; data_addr = BASE + 32'h4; #1; exp_rd++;
    checks++; if (dmem_data !== 32'h2222_2222) begin errors++; $display("FAIL err_mem_kept got=%h exp=22222222", dmem_data); end
    @(negedge clk); idle();
  endtask

  task automatic test_busy_access();
    int n;
    @(negedge clk); rst = 1'b1; #1;
    exp_rd = 0; exp_wr = 0;
    checks++; if ({err_range, err_align} !== 2'b00 || wr_count !== 16'h0 || rd_count !== 16'h0) begin errors++; $display("FAIL async_clear got=%b%b %0d/%0d exp=00 0/0", err_range, err_align, wr_count, rd_count); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    dmem_w = 1'b1; data_addr = BASE; w_data = 32'hFFFF_FFFF;
    @(negedge clk); idle(); #1;
    checks++; if (err_busy !== 1'b1 || err_addr !== BASE) begin errors++; $display("FAIL busy_err got=%b/%h exp=1/10010000", err_busy, err_addr); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL busy_wr_count got=%0d exp=0", wr_count); end
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_timeout got=%b exp=0", busy); end
    @(negedge clk); dmem_r = 1'b1; data_addr = BASE; #1; exp_rd++;
    checks++; if (dmem_data !== 32'h0) begin errors++; $display("FAIL busy_write_dropped got=%h exp=0", dmem_data); end
    @(negedge clk); idle();
  endtask

  task automatic test_saturation();
    @(negedge clk); dmem_r = 1'b1; data_addr = BASE + 32'h8;
    repeat (65540) @(posedge clk);
    @(negedge clk); idle(); #1;
    checks++; if (rd_count !== 16'hFFFF) begin errors++; $display("FAIL rd_saturate got=%h exp=ffff", rd_count); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL wr_unchanged got=%h exp=0", wr_count); end
  endtask

  task automatic test_midsweep_reset();
    int n;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (rd_count !== 16'h0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reset got=%h/%b exp=0/1", rd_count, busy); end
    @(negedge clk); rst = 1'b0; n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL mid_sweep_len got=%0d exp=%0d", n, DEPTH); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write_read();
    test_simul_rw();
    test_errors();
    test_busy_access();
    test_saturation();
    test_midsweep_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
